// File: rtl/repeat_consumer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | repeat_consumer                                                            |
// | Emits each reference word once per repeat token taken from the repsig      |
// | stream. Optional macro REPEAT_CONSUMER_ERR_CHECK_EN adds sticky proto_err. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+

module repeat_consumer_fifo #(
    parameter int DATA_W = 17,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] data_o,
    output logic              empty_o,
    output logic              full_o
);
    localparam int c_aw = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [c_aw:0]     wr_ptr_q;
    logic [c_aw:0]     rd_ptr_q;

    always_ff @(posedge clk) begin
        if (!rst_n || clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + (c_aw+1)'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + (c_aw+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q[c_aw-1:0]] <= data_i;
    end

    assign data_o  = mem_q[rd_ptr_q[c_aw-1:0]];
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[c_aw] != rd_ptr_q[c_aw]) &&
                     (wr_ptr_q[c_aw-1:0] == rd_ptr_q[c_aw-1:0]);
endmodule

module repeat_consumer #(
    parameter int DATA_W     = 17,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clk_en,
    input  logic              flush,
    input  logic              tile_en,
    input  logic [DATA_W-1:0] ref_data_in,
    input  logic              ref_data_in_valid,
    output logic              ref_data_in_ready,
    input  logic [DATA_W-1:0] repsig_data_in,
    input  logic              repsig_data_in_valid,
    output logic              repsig_data_in_ready,
    output logic [DATA_W-1:0] ref_data_out,
    output logic              ref_data_out_valid,
    input  logic              ref_data_out_ready
`ifdef REPEAT_CONSUMER_ERR_CHECK_EN
    ,
    output logic              proto_err
`endif
);
    localparam logic [DATA_W-1:0] c_done_tok = DATA_W'(17'h10100);

    typedef enum logic [0:0] {ST_RUN = 1'b0, ST_DONE = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic              out_valid_q, out_valid_d;

    logic              w_act, w_live;
    logic              w_ref_push, w_rep_push, w_ref_pop, w_rep_pop;
    logic              w_ref_empty, w_ref_full, w_rep_empty, w_rep_full;
    logic [DATA_W-1:0] w_ref_head, w_rep_head, w_emit_word;
    logic              w_emit, w_err, w_out_pop, w_slot_free;
    logic              w_ref_tok, w_ref_done, w_rep_tok, w_rep_done;

    assign w_act  = clk_en & tile_en;
    assign w_live = rst_n & ~flush;

    assign ref_data_in_ready    = w_live & tile_en & ~w_ref_full;
    assign repsig_data_in_ready = w_live & tile_en & ~w_rep_full;
    assign w_ref_push = ref_data_in_valid & ref_data_in_ready & clk_en;
    assign w_rep_push = repsig_data_in_valid & repsig_data_in_ready & clk_en;

    repeat_consumer_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_ref_fifo (
        .clk(clk), .rst_n(rst_n), .clr_i(flush),
        .push_i(w_ref_push), .data_i(ref_data_in), .pop_i(w_ref_pop),
        .data_o(w_ref_head), .empty_o(w_ref_empty), .full_o(w_ref_full)
    );

    repeat_consumer_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_rep_fifo (
        .clk(clk), .rst_n(rst_n), .clr_i(flush),
        .push_i(w_rep_push), .data_i(repsig_data_in), .pop_i(w_rep_pop),
        .data_o(w_rep_head), .empty_o(w_rep_empty), .full_o(w_rep_full)
    );

    assign w_out_pop   = out_valid_q & ref_data_out_ready & w_act;
    assign w_slot_free = ~out_valid_q | w_out_pop;
    assign w_ref_tok   = w_ref_head[16];
    assign w_ref_done  = (w_ref_head == c_done_tok);
    assign w_rep_tok   = w_rep_head[16];
    assign w_rep_done  = (w_rep_head == c_done_tok);

    always_comb begin
        state_d     = state_q;
        w_ref_pop   = 1'b0;
        w_rep_pop   = 1'b0;
        w_emit      = 1'b0;
        w_emit_word = '0;
        w_err       = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (w_act && !w_ref_empty && !w_rep_empty && w_slot_free) begin
                    if (!w_ref_tok) begin
                        if (!w_rep_tok) begin
                            w_emit      = 1'b1;
                            w_emit_word = w_ref_head;
                            w_rep_pop   = 1'b1;
                        end else if (w_rep_done) begin
                            w_ref_pop = 1'b1;
                            w_err     = 1'b1;
                        end else begin
                            w_emit      = 1'b1;
                            w_emit_word = w_rep_head;
                            w_ref_pop   = 1'b1;
                            w_rep_pop   = 1'b1;
                        end
                    end else if (!w_ref_done) begin
                        // Reference stops are absorbed; output stops come from repsig.
                        w_ref_pop = 1'b1;
                    end else if (!w_rep_tok) begin
                        w_rep_pop = 1'b1;
                        w_err     = 1'b1;
                    end else if (!w_rep_done) begin
                        w_emit      = 1'b1;
                        w_emit_word = w_rep_head;
                        w_rep_pop   = 1'b1;
                    end else begin
                        w_emit      = 1'b1;
                        w_emit_word = c_done_tok;
                        w_ref_pop   = 1'b1;
                        w_rep_pop   = 1'b1;
                        state_d     = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (w_act && (w_out_pop || !out_valid_q)) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (w_out_pop) out_valid_d = 1'b0;
        if (w_emit) begin
            out_d       = w_emit_word;
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            state_q     <= ST_RUN;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign ref_data_out       = out_q;
    assign ref_data_out_valid = out_valid_q & tile_en;

`ifdef REPEAT_CONSUMER_ERR_CHECK_EN
    logic proto_err_q;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) proto_err_q <= 1'b0;
        else if (w_err)      proto_err_q <= 1'b1;
    end

    assign proto_err = proto_err_q;
`else
    logic unused_err;
    assign unused_err = w_err;
`endif
endmodule
`default_nettype wire

// File: tb/tb_repeat_consumer.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for repeat_consumer: table of directed streams, hand-written reset/flush/
// clock-enable sequences, and random streams checked against a list-level model.
module tb_repeat_consumer;
    localparam logic [16:0] S0 = 17'h10000;
    localparam logic [16:0] S1 = 17'h10001;
    localparam logic [16:0] DN = 17'h10100;
    localparam logic [16:0] RR = 17'h00000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0, clk_en = 1'b1, flush = 1'b0, tile_en = 1'b1;
    logic [16:0] ref_data_in = '0, repsig_data_in = '0;
    logic        ref_data_in_valid = 1'b0, repsig_data_in_valid = 1'b0;
    logic        ref_data_in_ready, repsig_data_in_ready;
    logic [16:0] ref_data_out;
    logic        ref_data_out_valid;
    logic        ref_data_out_ready = 1'b1;
`ifdef REPEAT_CONSUMER_ERR_CHECK_EN
    logic        proto_err;
`endif

    always #5 clk = ~clk;

    repeat_consumer dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .flush(flush), .tile_en(tile_en),
        .ref_data_in(ref_data_in), .ref_data_in_valid(ref_data_in_valid),
        .ref_data_in_ready(ref_data_in_ready),
        .repsig_data_in(repsig_data_in), .repsig_data_in_valid(repsig_data_in_valid),
        .repsig_data_in_ready(repsig_data_in_ready),
        .ref_data_out(ref_data_out), .ref_data_out_valid(ref_data_out_valid),
        .ref_data_out_ready(ref_data_out_ready)
`ifdef REPEAT_CONSUMER_ERR_CHECK_EN
        , .proto_err(proto_err)
`endif
    );

    typedef struct {
        int          nr;
        logic [16:0] r[8];
        int          ns;
        logic [16:0] s[8];
        int          ne;
        logic [16:0] e[8];
        int          om;
        int          sk;
    } vec_t;

    vec_t        tbl[5];
    logic [16:0] sref[$], srep[$], got[$], expq[$];
    int          ref_idx, rep_idx, cyc, skew_g, freeze_g, om_g, vr_g;
    int          first_pair, first_valid, stall_err, freeze_err;
    bit          ref_low, rep_low, early_out, prev_stall, frz_valid;
    logic [16:0] prev_word, frz_word;
    int          passes = 0, checks = 0;

    task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    endtask

    task automatic drive();
        ref_data_in_valid    = (ref_idx < sref.size()) && (cyc >= skew_g) &&
                               (vr_g == 0 || $urandom_range(0, 2) != 0);
        ref_data_in          = (ref_idx < sref.size()) ? sref[ref_idx] : '0;
        repsig_data_in_valid = (rep_idx < srep.size()) && (vr_g == 0 || $urandom_range(0, 2) != 0);
        repsig_data_in       = (rep_idx < srep.size()) ? srep[rep_idx] : '0;
        case (om_g)
            0:       ref_data_out_ready = 1'b1;
            1:       ref_data_out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            default: ref_data_out_ready = ($urandom_range(0, 1) == 1);
        endcase
        clk_en  = !(freeze_g >= 0 && cyc >= freeze_g && cyc < freeze_g + 5);
        tile_en = (vr_g == 0) ? 1'b1 : ($urandom_range(0, 9) != 0);
    endtask

    task automatic step();
        bit rf, rp, of;
        #1;
        rf = ref_data_in_valid & ref_data_in_ready & clk_en & tile_en;
        rp = repsig_data_in_valid & repsig_data_in_ready & clk_en & tile_en;
        of = ref_data_out_valid & ref_data_out_ready & clk_en & tile_en;
        if (tile_en && !ref_data_in_ready)    ref_low = 1'b1;
        if (tile_en && !repsig_data_in_ready) rep_low = 1'b1;
        if (ref_data_out_valid && first_valid < 0) first_valid = cyc;
        if (skew_g > 0 && ref_data_out_valid && cyc <= skew_g + 1) early_out = 1'b1;
        if (tile_en) begin
            if (prev_stall && !(ref_data_out_valid && ref_data_out == prev_word)) stall_err++;
            prev_stall = ref_data_out_valid && !(ref_data_out_ready && clk_en);
            prev_word  = ref_data_out;
        end
        if (freeze_g >= 0) begin
            if (cyc == freeze_g) begin
                frz_word  = ref_data_out;
                frz_valid = ref_data_out_valid;
            end else if (cyc > freeze_g && cyc <= freeze_g + 5 &&
                         {ref_data_out_valid, ref_data_out} != {frz_valid, frz_word}) begin
                freeze_err++;
            end
        end
        if (of) got.push_back(ref_data_out);
        @(posedge clk);
        @(negedge clk);
        if (rf) ref_idx++;
        if (rp) rep_idx++;
        if (first_pair < 0 && ref_idx > 0 && rep_idx > 0) first_pair = cyc;
        cyc++;
    endtask

    task automatic run_stream(input int om, input int vr, input int sk, input int ab, input int fz);
        bit done;
        om_g = om; vr_g = vr; skew_g = sk; freeze_g = fz;
        ref_idx = 0; rep_idx = 0; cyc = 0;
        first_pair = -1; first_valid = -1; stall_err = 0; freeze_err = 0;
        ref_low = 0; rep_low = 0; early_out = 0; prev_stall = 0;
        got.delete();
        done = 0;
        while (!done && cyc < 600) begin
            drive();
            step();
            if (got.size() > 0 && got[got.size()-1] == DN) done = 1;
            if (ab > 0 && got.size() >= ab) done = 1;
        end
        if (!done) chk(0, "stream_timeout", cyc, 600);
        ref_data_in_valid = 0; repsig_data_in_valid = 0;
        clk_en = 1; tile_en = 1; ref_data_out_ready = 1;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic compare_exp(input string nm);
        chk(got.size() == expq.size(), {nm, "_len"}, got.size(), expq.size());
        for (int i = 0; i < expq.size(); i++)
            if (i < got.size()) chk(got[i] == expq[i], $sformatf("%s_w%0d", nm, i), got[i], expq[i]);
    endtask

    // List-level reference: walk both streams applying the head-pair rules.
    task automatic model();
        int i, j;
        logic [16:0] a, b;
        i = 0; j = 0;
        expq.delete();
        while (i < sref.size() && j < srep.size()) begin
            a = sref[i]; b = srep[j];
            if (!a[16] && !b[16])      begin expq.push_back(a); j++; end
            else if (!a[16] && b == DN) i++;
            else if (!a[16])           begin expq.push_back(b); i++; j++; end
            else if (a != DN)          i++;
            else if (!b[16])           j++;
            else if (b != DN)          begin expq.push_back(b); j++; end
            else                       begin expq.push_back(DN); i++; j++; end
        end
    endtask

    task automatic do_reset(input bit use_flush);
        ref_data_in_valid = 0; repsig_data_in_valid = 0;
        if (use_flush) flush = 1; else rst_n = 0;
        #1;
        chk(!ref_data_in_ready && !repsig_data_in_ready, use_flush ? "flush_ready0" : "rst_ready0",
            {ref_data_in_ready, repsig_data_in_ready}, 0);
        @(posedge clk);
        @(negedge clk);
        flush = 0; rst_n = 1;
        #1;
        chk(ref_data_in_ready && repsig_data_in_ready && !ref_data_out_valid && ref_data_out == 0,
            use_flush ? "flush_state" : "rst_state",
            {ref_data_in_ready, repsig_data_in_ready, ref_data_out_valid, 12'h0, ref_data_out}, 32'hc0000000);
    endtask

    task automatic load_vec(input int k);
        sref.delete(); srep.delete(); expq.delete();
        for (int i = 0; i < tbl[k].nr; i++) sref.push_back(tbl[k].r[i]);
        for (int i = 0; i < tbl[k].ns; i++) srep.push_back(tbl[k].s[i]);
        for (int i = 0; i < tbl[k].ne; i++) expq.push_back(tbl[k].e[i]);
    endtask

    task automatic load_fresh();
        sref = '{17'd9, DN};
        srep = '{RR, S0, DN};
        expq = '{17'd9, S0, DN};
    endtask

    initial begin
        tbl[0] = '{nr: 4, r: '{17'd5, 17'd7, S0, DN, 0, 0, 0, 0},
                   ns: 7, s: '{RR, RR, S0, RR, S0, S1, DN, 0},
                   ne: 7, e: '{17'd5, 17'd5, S0, 17'd7, S0, S1, DN, 0}, om: 0, sk: 0};
        tbl[1] = tbl[0]; tbl[1].om = 1;
        tbl[2] = '{nr: 3, r: '{17'd3, 17'd4, DN, 0, 0, 0, 0, 0},
                   ns: 4, s: '{S0, RR, S0, DN, 0, 0, 0, 0},
                   ne: 4, e: '{S0, 17'd4, S0, DN, 0, 0, 0, 0}, om: 0, sk: 0};
        tbl[3] = tbl[0]; tbl[3].sk = 10;
        tbl[4] = '{nr: 1, r: '{DN, 0, 0, 0, 0, 0, 0, 0},
                   ns: 2, s: '{17'h0abcd, DN, 0, 0, 0, 0, 0, 0},
                   ne: 1, e: '{DN, 0, 0, 0, 0, 0, 0, 0}, om: 0, sk: 0};

        @(negedge clk);
        do_reset(0);

        for (int k = 0; k < 5; k++) begin
            load_vec(k);
            run_stream(tbl[k].om, 0, tbl[k].sk, 0, -1);
            compare_exp($sformatf("vec%0d", k));
            chk(stall_err == 0, $sformatf("vec%0d_stall_stable", k), stall_err, 0);
            if (k == 0) chk(first_valid - first_pair == 2, "first_latency", first_valid - first_pair, 2);
            if (tbl[k].om == 1) chk(ref_low, "bp_ref_ready_low", ref_low, 1);
            if (tbl[k].sk > 0) begin
                chk(rep_low, "skew_rep_ready_low", rep_low, 1);
                chk(!early_out, "skew_no_early_out", early_out, 0);
            end
        end
`ifdef REPEAT_CONSUMER_ERR_CHECK_EN
        chk(proto_err == 1'b1, "proto_err_set", proto_err, 1);
        do_reset(1);
        chk(proto_err == 1'b0, "proto_err_flush", proto_err, 0);
`endif

        // Mid-stream reset, then flush, each followed by a fresh stream.
        for (int m = 0; m < 2; m++) begin
            load_vec(0);
            run_stream(0, 0, 0, 2, -1);
            do_reset(m == 1);
            load_fresh();
            run_stream(0, 0, 0, 0, -1);
            compare_exp(m == 1 ? "after_flush" : "after_rst");
        end

        load_vec(0);
        run_stream(0, 0, 0, 0, 4);
        compare_exp("freeze");
        chk(freeze_err == 0, "clk_en_freeze", freeze_err, 0);

        for (int t = 0; t < 40; t++) begin
            int n;
            sref.delete(); srep.delete();
            n = $urandom_range(0, 5);
            for (int i = 0; i < n; i++)
                if ($urandom_range(0, 9) < 7) sref.push_back({1'b0, 16'($urandom)});
                else sref.push_back(S0 | 17'($urandom_range(0, 2)));
            sref.push_back(DN);
            n = $urandom_range(0, 8);
            for (int i = 0; i < n; i++)
                if ($urandom_range(0, 9) < 6) srep.push_back({1'b0, 16'($urandom)});
                else srep.push_back(S0 | 17'($urandom_range(0, 2)));
            srep.push_back(DN);
            model();
            run_stream(2, 1, 0, 0, -1);
            compare_exp($sformatf("rnd%0d", t));
            chk(stall_err == 0, $sformatf("rnd%0d_stall_stable", t), stall_err, 0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
`default_nettype wire
